// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction-fetch front end:
//   XLEN          - datapath / address width
//   PC_INC        - byte increment between sequential instruction words
//   fetch_state_t - request-side FSM state
//   fetch_entry_t - one prefetch FIFO entry {pc, instr}
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   push, push_data - write one entry at the tail
//   pop             - drop the head entry (caller guarantees count != 0)
//   flush           - empty the FIFO; overrides push and pop
//   count           - current occupancy
//   count_next      - occupancy after this cycle's push/pop/flush
//   head            - entry at the read pointer
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next,
   output fetch_entry_t head
);

   fetch_entry_t     mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_next;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Storage carries no reset; entries are only observed while count != 0.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end: owns the fetch PC, issues word requests to
// instruction memory over REQ/ACK, buffers returned words in a prefetch FIFO
// and presents {pc, instr} to decode with valid/ready. A redirect flushes
// buffered words and discards any in-flight response.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   imem_req, imem_addr           - request to instruction memory
//   imem_ack, imem_rdata          - completion and returned word
//   instr_valid, instr, instr_pc  - FIFO head towards decode
//   instr_ready                   - decode takes the head
//   redirect, redirect_pc         - branch/jump strobe and target
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no request outstanding
// BUSY  | request outstanding, its response is kept
// FLUSH | request outstanding, its response is discarded
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t    state;
   logic [XLEN-1:0] f_pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] f_pc_inc;
   logic [XLEN-1:0] redirect_tgt;
   logic            push;
   logic            pop;
   logic            has_room;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   fetch_entry_t    push_data;
   fetch_entry_t    head;

   assign redirect_tgt = redirect_pc & ~XLEN'(3);
   assign f_pc_inc     = f_pc + PC_INC;

   // A redirect drops any completing response and wins over a same-cycle pop.
   assign push = (state == BUSY) && imem_ack && !redirect;
   assign pop  = instr_valid && instr_ready && !redirect;

   assign push_data.pc    = req_addr;
   assign push_data.instr = imem_rdata;

   // Issue only if the slot for the new request is still free after this
   // cycle's push/pop, which is what rules out FIFO overflow.
   assign has_room = count_next < CW'(FIFO_DEPTH);

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .flush      (redirect),
      .count      (count),
      .count_next (count_next),
      .head       (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         f_pc     <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  f_pc <= redirect_tgt;
               end else if (has_room) begin
                  req_addr <= f_pc;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (imem_ack && redirect) begin
                  f_pc     <= redirect_tgt;
                  req_addr <= redirect_tgt;
               end else if (imem_ack) begin
                  f_pc <= f_pc_inc;
                  if (has_room) begin
                     req_addr <= f_pc_inc;
                  end else begin
                     state <= IDLE;
                  end
               end else if (redirect) begin
                  f_pc  <= redirect_tgt;
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (redirect) f_pc <= redirect_tgt;
               if (imem_ack) begin
                  // A redirect landing on the discarded completion retargets
                  // the new request as well, keeping req_addr == f_pc in BUSY.
                  req_addr <= redirect ? redirect_tgt : f_pc;
                  state    <= BUSY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req    = (state != IDLE);
   assign imem_addr   = req_addr;
   assign instr_valid = (count != '0);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;

endmodule
